cam_capture_ctrl: RTL and testbench
===================================

Name: cam_capture_ctrl

Overview:
Sequences capture of one OV7670 frame into the on-chip frame buffer.
- Arms on a start request and aligns to the camera frame and line syncs.
- Packs each RGB565 byte pair into one RGB332 pixel and issues the buffer write with a bounded, saturating pixel address.
- Sits between the camera input pins and the frame-buffer write port; replaces free-running address counting with a frame-aware controller.

Parameters:
ADDR_W, 15, width of frame-buffer write address.
FRAME_PIXELS, 19200, pixels stored per frame (160x120); addresses 0..FRAME_PIXELS-1.

Ports:
clk  input  1  camera pixel clock (PCLK); all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  capture request; sampled in IDLE only
cont  input  1  1 = re-arm automatically after each frame
vsync  input  1  camera VSYNC, high between frames
href  input  1  camera HREF, high while line bytes valid
data  input  8  camera byte bus
mem_addr  output  ADDR_W  frame-buffer write address
mem_data  output  8  RGB332 pixel {R[2:0],G[2:0],B[1:0]}
mem_we  output  1  one-cycle write strobe
busy  output  1  high in ARM, SYNC and CAPTURE
done  output  1  one-cycle pulse at frame end
overflow  output  1  sticky: frame delivered more than FRAME_PIXELS pixels

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; mem_addr=0, mem_data=0, mem_we=0, busy=0, done=0, overflow=0; byte phase=0; pixel count=0.
- States:
  - IDLE: start=1 -> ARM.
  - ARM: wait for vsync=1 -> SYNC. Ensures capture never begins mid-frame.
  - SYNC: vsync=0 -> CAPTURE. Pixel count cleared to 0, byte phase 0, overflow cleared.
  - CAPTURE: vsync=1 (frame end) -> DONE.
  - DONE: done=1 for exactly this cycle. Then -> SYNC if cont=1, else -> IDLE. vsync is already high, so SYNC proceeds directly on vsync falling.
- Byte phase, CAPTURE only:
  - href=1, phase 0: latch data as byte1 (RRRRRGGG); phase becomes 1.
  - href=1, phase 1: form pixel; phase becomes 0.
  - href=0: phase forced to 0; an odd trailing byte is discarded.
- Pixel packing: R = byte1[7:5], G = byte1[2:0], B = byte2[4:3], where byte2 is GGGBBBBB.
- Write timing (latency 1):
  - On the clk edge that samples the phase-1 byte with count < FRAME_PIXELS: next cycle mem_we=1, mem_data=packed pixel, mem_addr=count.
  - Count increments on the same edge.
  - mem_we is low in every other cycle; there are never back-to-back writes.
- Saturation: once count = FRAME_PIXELS, further phase-1 bytes produce no write, count holds, overflow=1. overflow stays set until the next SYNC->CAPTURE transition or reset.
- Short frame (fewer pixels): unwritten addresses are untouched; done still pulses at vsync.
- mem_addr holds its last value between writes.
- start is ignored outside IDLE. start and rst asserted together: rst wins.
- Reset mid-frame returns to IDLE; the next capture re-aligns via ARM, so no partial-frame writes occur.
- vsync rising while href=1 (malformed): frame end takes priority; the in-flight pixel is dropped.
- busy: low in IDLE, high in ARM, SYNC and CAPTURE. In DONE, busy=0 if cont=0, busy=1 if cont=1.
- count width is ADDR_W+1 so the compare at FRAME_PIXELS never wraps. count is not required to wrap at 2^ADDR_W.

Test Plan:
- Reset then start pulse with vsync already low -> stays in ARM, no mem_we; raise then drop vsync -> CAPTURE, busy=1.
- One line, href high for 4 bytes 0xE0,0x00 / 0x07,0xFF -> two writes: addr 0 data 0xE0, addr 1 data 0x1F; each mem_we exactly 1 cycle, 1 cycle after the second byte.
- Full 160x120 frame of 320-byte lines then vsync rise -> 19200 writes, last addr 19199, done=1 for one cycle, overflow=0, back to IDLE with busy=0.
- Frame of 121 lines -> 19200 writes only, overflow=1; next captured frame clears overflow at CAPTURE entry.
- Line with odd byte count 5 -> 2 writes; the fifth byte is dropped; next line starts at phase 0.
- cont=1 over two frames -> addr restarts at 0 in frame 2, two done pulses; rst asserted mid-line -> all outputs 0, IDLE, no write on the following cycle.

Source files
------------

// File: rtl/cam_capture_ctrl.sv
// rtl/cam_capture_ctrl.sv - frame-aware OV7670 capture sequencer writing RGB332 pixels to a frame buffer
module cam_capture_ctrl #(
    parameter int ADDR_W       = 15,
    parameter int FRAME_PIXELS = 19200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cont,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_SYNC,
        S_CAPTURE,
        S_DONE
    } state_t;

    // One extra count bit so the comparison against FRAME_PIXELS never wraps.
    localparam logic [ADDR_W:0] FRAME_PIX_C = FRAME_PIXELS[ADDR_W:0];
    localparam logic [ADDR_W:0] COUNT_ONE_C = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic              phase_q, phase_d;
    logic [7:0]        byte1_q, byte1_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        pix_q, pix_d;
    logic              we_q, we_d;
    logic              ovf_q, ovf_d;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        byte1_d = byte1_q;
        count_d = count_q;
        addr_d  = addr_q;
        pix_d   = pix_q;
        we_d    = 1'b0;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (vsync) begin
                    state_d = S_SYNC;
                end
            end
            S_SYNC: begin
                if (!vsync) begin
                    state_d = S_CAPTURE;
                    count_d = '0;
                    phase_d = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            S_CAPTURE: begin
                // Frame end wins over any half-assembled pixel.
                if (vsync) begin
                    state_d = S_DONE;
                    phase_d = 1'b0;
                end else if (href) begin
                    if (!phase_q) begin
                        byte1_d = data;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (count_q < FRAME_PIX_C) begin
                            we_d    = 1'b1;
                            pix_d   = {byte1_q[7:5], byte1_q[2:0], data[4:3]};
                            addr_d  = count_q[ADDR_W-1:0];
                            count_d = count_q + COUNT_ONE_C;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end else begin
                    phase_d = 1'b0;
                end
            end
            S_DONE: begin
                state_d = cont ? S_SYNC : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            phase_q <= 1'b0;
            byte1_q <= '0;
            count_q <= '0;
            addr_q  <= '0;
            pix_q   <= '0;
            we_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            byte1_q <= byte1_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            pix_q   <= pix_d;
            we_q    <= we_d;
            ovf_q   <= ovf_d;
        end
    end

    assign mem_addr = addr_q;
    assign mem_data = pix_q;
    assign mem_we   = we_q;
    assign overflow = ovf_q;
    assign done     = (state_q == S_DONE);
    assign busy     = (state_q == S_ARM) || (state_q == S_SYNC) || (state_q == S_CAPTURE)
                   || ((state_q == S_DONE) && cont);

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// tb/tb_cam_capture_ctrl.sv - self-checking bench for cam_capture_ctrl
module tb_cam_capture_ctrl;

    localparam int AW = 15;
    localparam int FP = 19200;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          cont = 1'b0;
    logic          vsync = 1'b0;
    logic          href = 1'b0;
    logic [7:0]    data = 8'h00;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic          mem_we;
    logic          busy;
    logic          done;
    logic          overflow;

    typedef struct {
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] px;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    px;
    } wr_t;

    vec_t vecs[6];
    wr_t  exp_q[$];
    int   n_vec = 0;
    int   n_fail = 0;
    int   exp_cnt = 0;
    bit   exp_ovf = 1'b0;
    bit   exp_we = 1'b0;
    bit   mon_en = 1'b0;

    cam_capture_ctrl #(.ADDR_W(AW), .FRAME_PIXELS(FP)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cont     (cont),
        .vsync    (vsync),
        .href     (href),
        .data     (data),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_we   (mem_we),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write scoreboard: strobe timing every cycle, address/data popped per write.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
            if (mem_we) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %0d data %0h expected no write", mem_addr, mem_data);
                end else begin
                    wr_t w;
                    w = exp_q.pop_front();
                    chk("wr_addr", {17'd0, mem_addr}, {17'd0, w.addr});
                    chk("wr_data", {24'd0, mem_data}, {24'd0, w.px});
                end
            end
        end
    end

    function automatic logic [7:0] pack(input logic [7:0] b1, input logic [7:0] b2);
        return {b1[7:5], b1[2:0], b2[4:3]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        exp_we = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        href = 1'b1;
        data = b;
        tick();
    endtask

    task automatic send_pixel(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] px);
        wr_t w;
        send_byte(b1);
        send_byte(b2);
        if (exp_cnt < FP) begin
            w.addr = exp_cnt[AW-1:0];
            w.px   = px;
            exp_q.push_back(w);
            exp_cnt++;
            exp_we = 1'b1;
        end else begin
            exp_ovf = 1'b1;
        end
    endtask

    task automatic send_rand_pixel();
        logic [7:0] b1, b2;
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        send_pixel(b1, b2, pack(b1, b2));
    endtask

    task automatic end_line();
        href = 1'b0;
        data = 8'h00;
        tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic enter_capture();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        tick();
        exp_cnt = 0;
        exp_ovf = 1'b0;
    endtask

    task automatic send_frame(input int lines, input int pix);
        for (int l = 0; l < lines; l++) begin
            for (int p = 0; p < pix; p++) send_rand_pixel();
            end_line();
        end
    endtask

    task automatic end_frame(input bit c);
        href  = 1'b0;
        vsync = 1'b1;
        tick();
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("busy_in_done", {31'd0, busy}, {31'd0, c});
        chk("overflow_at_done", {31'd0, overflow}, {31'd0, exp_ovf});
        tick();
        chk("done_clear", {31'd0, done}, 32'd0);
        chk("busy_after_done", {31'd0, busy}, {31'd0, c});
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_addr"}, {17'd0, mem_addr}, 32'd0);
        chk({tag, "_data"}, {24'd0, mem_data}, 32'd0);
        chk({tag, "_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{8'hE0, 8'h00, 8'hE0};
        vecs[1] = '{8'h07, 8'hFF, 8'h1F};
        vecs[2] = '{8'hFF, 8'hFF, 8'hFF};
        vecs[3] = '{8'h1F, 8'hE0, 8'h1C};
        vecs[4] = '{8'hA5, 8'h5A, 8'hB7};
        vecs[5] = '{8'h48, 8'h18, 8'h43};

        tick();
        tick();
        chk_reset_outputs("reset");
        mon_en = 1'b1;
        rst = 1'b0;
        tick();

        // Start with vsync low: must sit in ARM and ignore line data.
        do_start();
        repeat (3) tick();
        chk("arm_busy", {31'd0, busy}, 32'd1);
        send_byte(8'hAA);
        send_byte(8'h55);
        end_line();
        enter_capture();
        chk("capture_busy", {31'd0, busy}, 32'd1);
        chk("capture_ovf", {31'd0, overflow}, 32'd0);

        for (int i = 0; i < 6; i++) send_pixel(vecs[i].b1, vecs[i].b2, vecs[i].px);
        end_line();
        tick();
        chk("addr_hold", {17'd0, mem_addr}, 32'(exp_cnt - 1));

        // Odd byte count: trailing byte dropped, next line starts at phase 0.
        send_rand_pixel();
        send_rand_pixel();
        send_byte(8'h3C);
        end_line();
        send_rand_pixel();
        end_line();
        chk("odd_line_addr", {17'd0, mem_addr}, 32'(exp_cnt - 1));

        // vsync rising mid-pixel: frame end, pixel dropped.
        send_byte(8'h12);
        vsync = 1'b1;
        href  = 1'b1;
        data  = 8'h34;
        tick();
        chk("malformed_done", {31'd0, done}, 32'd1);
        chk("malformed_busy", {31'd0, busy}, 32'd0);
        href = 1'b0;
        tick();
        chk("malformed_done_clear", {31'd0, done}, 32'd0);

        // Full 160x120 frame.
        do_start();
        enter_capture();
        send_frame(120, 160);
        chk("full_ovf", {31'd0, overflow}, 32'd0);
        chk("full_last_addr", {17'd0, mem_addr}, 32'd19199);
        chk("full_all_written", exp_q.size(), 32'd0);
        end_frame(1'b0);

        // 121-line frame saturates at FRAME_PIXELS.
        do_start();
        enter_capture();
        send_frame(120, 160);
        send_rand_pixel();
        send_rand_pixel();
        end_line();
        chk("sat_ovf", {31'd0, overflow}, 32'd1);
        chk("sat_addr", {17'd0, mem_addr}, 32'd19199);
        end_frame(1'b0);
        do_start();
        vsync = 1'b1;
        tick();
        chk("ovf_sticky_sync", {31'd0, overflow}, 32'd1);
        vsync = 1'b0;
        tick();
        exp_cnt = 0;
        exp_ovf = 1'b0;
        chk("ovf_cleared", {31'd0, overflow}, 32'd0);
        send_rand_pixel();
        end_line();
        end_frame(1'b0);

        // Continuous mode over two frames.
        cont = 1'b1;
        do_start();
        enter_capture();
        for (int i = 0; i < 3; i++) send_rand_pixel();
        end_line();
        end_frame(1'b1);
        enter_capture();
        send_rand_pixel();
        send_rand_pixel();
        end_line();
        chk("cont_frame2_addr", {17'd0, mem_addr}, 32'd1);
        cont = 1'b0;
        end_frame(1'b0);

        // Reset mid-line, then reset together with start.
        do_start();
        enter_capture();
        send_rand_pixel();
        send_byte(8'h55);
        href = 1'b1;
        data = 8'h66;
        rst  = 1'b1;
        tick();
        chk_reset_outputs("midline_rst");
        rst  = 1'b0;
        href = 1'b0;
        tick();
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        tick();
        chk("rst_beats_start", {31'd0, busy}, 32'd0);

        tick();
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
